spike_frame_collector: RTL and testbench
========================================

Name: spike_frame_collector

Overview:
- Parametrised successor to the SNN packet-load controller.
- Sequences packet reads from the input-packet buffer into the neuron grid and accumulates grid output spikes into a NUM_OUT-wide frame vector per tick.
- Delivers each frame over a valid/ready handshake with a popcount, and runs a configurable end-of-run drain.
- Sits between the clk-domain side of the CPU packet FIFO and the spike output FIFO/CSR bank, all in the snn clk domain.

Parameters:
- NUM_OUT, 250, number of output neurons / frame vector width.
- ID_W, 8, width of grid output neuron id.
- DRAIN_TICKS, 3, ticks captured after load_end before completion (1..255).
- CNT_W, $clog2(NUM_OUT+1), width of spike popcount.

Ports:
- clk  in  1  snn clock
- reset_n  in  1  async active-low reset
- in_empty  in  1  input packet buffer empty
- in_ren  out  1  read enable to input packet buffer
- tick  in  1  grid tick strobe, 1 cycle
- grid_idle  in  1  grid finished current tick's processing
- spike_en  in  1  capture frames during COMPUTE
- load_end  in  1  CPU has finished loading packets
- out_valid  in  1  grid output spike strobe
- out_id  in  ID_W  neuron id of output spike
- spike_valid  out  1  frame available
- spike_ready  in  1  downstream accepts frame
- spike_vec  out  NUM_OUT  captured frame, MSB = neuron 0
- spike_cnt  out  CNT_W  popcount of spike_vec
- complete  out  1  run complete (sticky)
- overflow  out  1  sticky: frame overwritten before accept
- bad_id  out  1  sticky: out_id >= NUM_OUT seen
- state  out  2  FSM state

Behaviour:
- Reset (async, reset_n=0): state=IDLE, accumulator=0, spike_vec=0, spike_cnt=0, spike_valid=0, complete=0, overflow=0, bad_id=0, drain counter=0. Reset mid-run aborts immediately; a pending frame is lost.
- FSM encoding: IDLE=0, LOAD=1, COMPUTE=2, DRAIN=3; registered, state output = state register.
- IDLE: stays while in_empty. On !in_empty -> LOAD, clearing complete, overflow and bad_id.
- LOAD: in_ren = (state==LOAD) && !in_empty, combinational, 0 in all other states. Goes to COMPUTE on in_empty.
- COMPUTE priority, highest first:
  - load_end -> DRAIN, drain counter cleared.
  - else grid_idle && !in_empty -> LOAD.
  - else stay.
- DRAIN:
  - Each tick increments the drain counter and captures a frame regardless of spike_en.
  - When the counter reaches DRAIN_TICKS -> IDLE and complete<=1 the same cycle. The tick that makes counter==DRAIN_TICKS is itself captured.
- Accumulator:
  - out_valid with out_id < NUM_OUT sets bit (NUM_OUT-1-out_id).
  - out_id >= NUM_OUT: no bit set, bad_id<=1.
  - Accumulates in every state.
- Tick:
  - Accumulator cleared on every tick.
  - out_valid in the same cycle as tick belongs to the new frame: its bit is set in the cleared accumulator.
- Capture (tick in COMPUTE with spike_en, or tick in DRAIN):
  - Next cycle: spike_vec = accumulator value before the tick-cycle clear, excluding same-cycle out_valid.
  - Next cycle: spike_cnt = its popcount, spike_valid=1.
  - Capture latency is 1 cycle after tick.
- Handshake:
  - spike_vec/spike_cnt stable while spike_valid && !spike_ready.
  - spike_valid && spike_ready drops spike_valid next cycle unless a capture occurs that cycle. In that case the new frame loads and spike_valid stays 1 with no overflow.
  - A capture while spike_valid && !spike_ready overwrites the frame and sets overflow.
- Tick in IDLE or LOAD: accumulator cleared, no capture.
- spike_cnt width rule: popcount is computed zero-extended to CNT_W and cannot saturate.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0, state=0, in_ren=0; release -> still IDLE while in_empty=1.
- Load sequence: buffer holds 4 packets (in_empty low 4 cycles) -> in_ren high exactly 4 cycles in LOAD, then state=2.
- Frame capture: spike_en=1, out_id=0,5,249 before tick -> cycle after tick, spike_valid=1, spike_vec bits 249,244,0 set, spike_cnt=3. Same-cycle out_id=7 with tick appears only in the next frame.
- Backpressure: spike_ready=0 across two captures -> overflow=1, second frame held. Capture in the same cycle as accept -> overflow stays 0.
- Bad id: out_id=250 -> bad_id=1, no vector bit set; cleared on next IDLE->LOAD.
- Drain: load_end in COMPUTE, DRAIN_TICKS=3 -> 3 frames captured with spike_en=0, complete=1 in the cycle of the 3rd tick's capture, state=IDLE; new packets -> complete clears on entering LOAD.

Source files
------------

// File: rtl/spike_frame_collector.sv
// rtl/spike_frame_collector.sv - packet-load sequencer and per-tick spike frame collector
module spike_frame_collector #(
    parameter int NUM_OUT     = 250,
    parameter int ID_W        = 8,
    parameter int DRAIN_TICKS = 3,
    parameter int CNT_W       = $clog2(NUM_OUT + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_empty,
    output logic               in_ren,
    input  logic               tick,
    input  logic               grid_idle,
    input  logic               spike_en,
    input  logic               load_end,
    input  logic               out_valid,
    input  logic [ID_W-1:0]    out_id,
    output logic               spike_valid,
    input  logic               spike_ready,
    output logic [NUM_OUT-1:0] spike_vec,
    output logic [CNT_W-1:0]   spike_cnt,
    output logic               complete,
    output logic               overflow,
    output logic               bad_id,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Neuron 0 lives in the MSB, so a spike for id n is this bit shifted right by n.
    localparam logic [NUM_OUT-1:0] TOP_BIT = {1'b1, {(NUM_OUT-1){1'b0}}};

    state_t             state_q;
    logic [7:0]         drain_cnt;
    logic [NUM_OUT-1:0] acc;
    logic [NUM_OUT-1:0] spike_bit;
    logic [NUM_OUT-1:0] acc_next;
    logic               id_ok;
    logic               capture;
    logic               drain_done;
    logic               start_load;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_OUT-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign id_ok      = 32'(out_id) < NUM_OUT;
    assign spike_bit  = (out_valid && id_ok) ? (TOP_BIT >> out_id) : '0;
    // A spike arriving with the tick belongs to the frame that the tick opens.
    assign acc_next   = (tick ? '0 : acc) | spike_bit;
    assign capture    = tick && ((state_q == COMPUTE && spike_en) || state_q == DRAIN);
    assign drain_done = (drain_cnt + 8'd1) == 8'(DRAIN_TICKS);
    assign start_load = (state_q == IDLE) && !in_empty;
    assign in_ren     = (state_q == LOAD) && !in_empty;
    assign state      = state_q;

    // Run sequencing, drain counting and the completion / bad-id sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            drain_cnt <= 8'd0;
            complete  <= 1'b0;
            bad_id    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!in_empty) begin
                        state_q  <= LOAD;
                        complete <= 1'b0;
                        bad_id   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_empty) begin
                        state_q <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (load_end) begin
                        state_q   <= DRAIN;
                        drain_cnt <= 8'd0;
                    end else if (grid_idle && !in_empty) begin
                        state_q <= LOAD;
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        drain_cnt <= drain_cnt + 8'd1;
                        if (drain_done) begin
                            state_q  <= IDLE;
                            complete <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // An out-of-range id is flagged even in the cycle a new run starts.
            if (out_valid && !id_ok) begin
                bad_id <= 1'b1;
            end
        end
    end

    // Spike accumulator for the frame currently being collected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    // Output frame register and valid/ready handshake with overwrite detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_vec   <= '0;
            spike_cnt   <= '0;
            spike_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (start_load) begin
                overflow <= 1'b0;
            end
            if (capture) begin
                spike_vec   <= acc;
                spike_cnt   <= popcount(acc);
                spike_valid <= 1'b1;
                if (spike_valid && !spike_ready) begin
                    overflow <= 1'b1;
                end
            end else if (spike_valid && spike_ready) begin
                spike_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spike_frame_collector.sv
// tb/tb_spike_frame_collector.sv - self-checking bench for spike_frame_collector
module tb_spike_frame_collector;

    localparam int NUM_OUT = 250;
    localparam int ID_W    = 8;
    localparam int CNT_W   = 8;

    typedef struct {
        int id0;
        int id1;
        int id2;
        int same;
        int cnt;
    } row_t;

    typedef struct {
        logic [NUM_OUT-1:0] vec;
        int                 cnt;
    } frame_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               in_empty = 1'b1;
    logic               in_ren;
    logic               tick = 1'b0;
    logic               grid_idle = 1'b0;
    logic               spike_en = 1'b1;
    logic               load_end = 1'b0;
    logic               out_valid = 1'b0;
    logic [ID_W-1:0]    out_id = '0;
    logic               spike_valid;
    logic               spike_ready = 1'b1;
    logic [NUM_OUT-1:0] spike_vec;
    logic [CNT_W-1:0]   spike_cnt;
    logic               complete;
    logic               overflow;
    logic               bad_id;
    logic [1:0]         state;

    int                 errors = 0;
    int                 checks = 0;
    logic               mon_en = 1'b0;
    logic [NUM_OUT-1:0] acc_m = '0;
    logic [NUM_OUT-1:0] last_frame = '0;
    frame_t             sb[$];

    spike_frame_collector #(
        .NUM_OUT(NUM_OUT), .ID_W(ID_W), .DRAIN_TICKS(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_empty(in_empty), .in_ren(in_ren),
        .tick(tick), .grid_idle(grid_idle), .spike_en(spike_en), .load_end(load_end),
        .out_valid(out_valid), .out_id(out_id), .spike_valid(spike_valid),
        .spike_ready(spike_ready), .spike_vec(spike_vec), .spike_cnt(spike_cnt),
        .complete(complete), .overflow(overflow), .bad_id(bad_id), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NUM_OUT-1:0] act, input logic [NUM_OUT-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the reference accumulator.
    task automatic cyc(input logic v, input int id, input logic t, input logic cap, input int ecnt, input logic r);
        frame_t f;
        @(negedge clk);
        out_valid   = v;
        out_id      = ID_W'(id);
        tick        = t;
        spike_ready = r;
        if (t) begin
            last_frame = acc_m;
            if (cap) begin
                f.vec = acc_m;
                f.cnt = (ecnt < 0) ? $countones(acc_m) : ecnt;
                sb.push_back(f);
            end
            acc_m = '0;
        end
        if (v && id < NUM_OUT) begin
            acc_m[NUM_OUT-1-id] = 1'b1;
        end
    endtask

    // Scoreboard: every accepted frame must match the oldest expected frame.
    always @(negedge clk) begin
        frame_t f;
        if (mon_en && reset_n && spike_valid && spike_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_frame", 1, 0);
            end else begin
                f = sb.pop_front();
                chk("sb_vec", spike_vec, f.vec);
                chk("sb_cnt", spike_cnt, f.cnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        row_t rows[5];
        int   pkts;
        int   reads;
        logic [NUM_OUT-1:0] fa;
        logic [NUM_OUT-1:0] fb;
        logic [NUM_OUT-1:0] fc;

        rows[0] = '{0, 5, 249, 7, 3};
        rows[1] = '{1, 1, -1, -1, 2};
        rows[2] = '{-1, -1, -1, -1, 0};
        rows[3] = '{248, 249, 250, -1, 2};
        rows[4] = '{249, 0, 100, -1, 3};

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_empty    = 1'($urandom);
            tick        = 1'($urandom);
            grid_idle   = 1'($urandom);
            spike_en    = 1'($urandom);
            load_end    = 1'($urandom);
            out_valid   = 1'($urandom);
            out_id      = ID_W'($urandom);
            spike_ready = 1'($urandom);
            chk("rst_state", state, 0);
            chk("rst_in_ren", in_ren, 0);
            chk("rst_valid", spike_valid, 0);
            chk("rst_vec", spike_vec, 0);
            chk("rst_cnt", spike_cnt, 0);
            chk("rst_flags", {complete, overflow, bad_id}, 0);
        end
        @(negedge clk);
        in_empty = 1'b1; tick = 1'b0; grid_idle = 1'b0; spike_en = 1'b1;
        load_end = 1'b0; out_valid = 1'b0; out_id = '0; spike_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        chk("idle_after_reset", state, 0);

        // Four packets in the buffer.
        pkts = 4;
        reads = 0;
        in_empty = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (in_ren) begin
                reads++;
                pkts--;
            end
            @(posedge clk);
            #1 in_empty = (pkts == 0);
        end
        chk("load_reads", reads, 4);
        chk("load_to_compute", state, 2);

        // Frame table in COMPUTE with spike_en.
        mon_en = 1'b1;
        foreach (rows[k]) begin
            if (rows[k].id0 >= 0) cyc(1, rows[k].id0, 0, 0, 0, 1);
            if (rows[k].id1 >= 0) cyc(1, rows[k].id1, 0, 0, 0, 1);
            if (rows[k].id2 >= 0) cyc(1, rows[k].id2, 0, 0, 0, 1);
            cyc(rows[k].same >= 0, (rows[k].same >= 0) ? rows[k].same : 0, 1, 1, rows[k].cnt, 1);
            cyc(0, 0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0, 1);
        end
        chk("bad_id_set", bad_id, 1);

        // Tick with spike_en low in COMPUTE does not capture.
        spike_en = 1'b0;
        cyc(1, 20, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("no_cap_spike_en0", spike_valid, 0);
        spike_en = 1'b1;
        chk("sb_empty_pre_bp", sb.size(), 0);

        // Backpressure: capture coinciding with accept, then overwrite.
        mon_en = 1'b0;
        cyc(1, 3, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        fa = last_frame;
        cyc(1, 11, 0, 0, 0, 0);
        chk("bp_valid_a", spike_valid, 1);
        chk("bp_vec_a", spike_vec, fa);
        cyc(0, 0, 1, 0, 0, 1);
        fb = last_frame;
        cyc(0, 0, 0, 0, 0, 0);
        chk("acc_cap_valid", spike_valid, 1);
        chk("acc_cap_vec", spike_vec, fb);
        chk("acc_cap_no_ovf", overflow, 0);
        cyc(1, 42, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        fc = last_frame;
        cyc(0, 0, 0, 0, 0, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_vec", spike_vec, fc);
        chk("ovf_cnt", spike_cnt, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_vec", spike_vec, fc);
        chk("hold_valid", spike_valid, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("accept_drops_valid", spike_valid, 0);
        mon_en = 1'b1;

        // Drain with spike_en low.
        spike_en = 1'b0;
        load_end = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        load_end = 1'b0;
        chk("enter_drain", state, 3);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 60 + k, 0, 0, 0, 1);
            cyc(0, 0, 1, 1, -1, 1);
            cyc(0, 0, 0, 0, 0, 1);
            if (k < 2) begin
                chk("drain_state", state, 3);
                chk("drain_not_complete", complete, 0);
            end else begin
                chk("drain_done_state", state, 0);
                chk("drain_complete", complete, 1);
            end
        end

        // New packets start a fresh run and clear the sticky flags.
        in_empty = 1'b0;
        cyc(0, 0, 0, 0, 0, 1);
        chk("restart_load", state, 1);
        chk("restart_complete_clr", complete, 0);
        chk("restart_bad_id_clr", bad_id, 0);
        chk("restart_ovf_clr", overflow, 0);
        chk("restart_in_ren", in_ren, 1);
        in_empty = 1'b1;
        cyc(0, 0, 0, 0, 0, 1);
        chk("restart_compute", state, 2);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
